// File: rtl/pixel_cmd_pkg.sv
// Shared types and defaults for the pixel command engine.
//   op_e    : host command opcodes
//   state_e : engine sequencing states
//   min10   : unsigned minimum used for clipping arithmetic
package pixel_cmd_pkg;

    typedef enum logic [1:0] {
        OP_WRITE_PIXEL = 2'd0,
        OP_READ_PIXEL  = 2'd1,
        OP_FILL_RECT   = 2'd2,
        OP_RESERVED    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    localparam int DEFAULT_SCREEN_WIDTH  = 320;
    localparam int DEFAULT_SCREEN_HEIGHT = 240;

    // Clipping math is 10 bits so x+width and y+height can never wrap.
    function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/pixel_command_engine_rect_scanner.sv
// rect_scanner: row-major pixel walker over an already-clipped rectangle.
//   clock, reset : system clock, synchronous active-high reset
//   load         : capture origin and clipped size, position at origin
//   advance      : step to the next pixel (x first, then wrap to next row)
//   startX/Y     : rectangle origin
//   width/height : clipped size, both >= 1 whenever load is used
//   x, y         : current pixel
//   last         : current pixel is the final one of the rectangle
module rect_scanner (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       advance,
    input  logic [8:0] startX,
    input  logic [7:0] startY,
    input  logic [9:0] width,
    input  logic [9:0] height,
    output logic [8:0] x,
    output logic [7:0] y,
    output logic       last
);

    logic [8:0] originX;
    logic [9:0] lastX;
    logic [9:0] lastY;
    logic       rowEnd;

    assign rowEnd = ({1'b0, x} == lastX);
    assign last   = rowEnd && ({2'b00, y} == lastY);

    always_ff @(posedge clock) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            originX <= '0;
            lastX   <= '0;
            lastY   <= '0;
        end else if (load) begin
            x       <= startX;
            y       <= startY;
            originX <= startX;
            lastX   <= {1'b0, startX} + width - 10'd1;
            lastY   <= {2'b00, startY} + height - 10'd1;
        end else if (advance) begin
            if (rowEnd) begin
                x <= originX;
                y <= y + 8'd1;
            end else begin
                x <= x + 9'd1;
            end
        end
    end

endmodule

// File: rtl/pixel_command_engine.sv
// pixel_command_engine: turns host drawing commands into single-pixel
// request/complete transactions toward the frame-buffer memory manager.
//   clock, reset           : system clock, synchronous active-high reset
//   cmdValid/cmdReady      : command handshake (ready only when idle)
//   cmdOp/X/Y/Width/Height/Color : command fields
//   readData/readValid     : READ_PIXEL result, one-cycle pulse
//   busy                   : command in progress
//   memoryXCoord/YCoord    : transaction coordinates
//   memoryWriteRequest/ReadRequest : request levels, held until completion
//   memoryWriteData        : write value
//   memoryReadData         : read value from the manager
//   memoryWriteComplete/ReadComplete : one-cycle completion pulses
module pixel_command_engine
    import pixel_cmd_pkg::*;
#(
    parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [1:0] cmdOp,
    input  logic [8:0] cmdX,
    input  logic [7:0] cmdY,
    input  logic [8:0] cmdWidth,
    input  logic [7:0] cmdHeight,
    input  logic [7:0] cmdColor,
    output logic [7:0] readData,
    output logic       readValid,
    output logic       busy,
    output logic [8:0] memoryXCoord,
    output logic [7:0] memoryYCoord,
    output logic       memoryWriteRequest,
    output logic       memoryReadRequest,
    output logic [7:0] memoryWriteData,
    input  logic [7:0] memoryReadData,
    input  logic       memoryWriteComplete,
    input  logic       memoryReadComplete
);

    state_e     state, nextState;
    op_e        op;
    logic       accept, issue, startCmd, advance, last;
    logic       xIn, yIn, readMiss, readDone;
    logic [9:0] x10, y10, effW, effH;

    logic       readyNext, writeReqNext, readReqNext, readValidNext;
    logic [7:0] readDataNext, writeDataNext;

    assign op       = op_e'(cmdOp);
    assign accept   = cmdValid && cmdReady;
    assign startCmd = accept && issue;
    assign advance  = (state == S_GAP) && !last;
    assign readDone = (state == S_READ) && memoryReadComplete;
    // An out-of-range read still answers, with zero data.
    assign readMiss = accept && (op == OP_READ_PIXEL) && !issue;

    // Clipping at accept; single-pixel ops are a 1x1 rectangle.
    always_comb begin
        x10  = {1'b0, cmdX};
        y10  = {2'b00, cmdY};
        xIn  = x10 < 10'(SCREEN_WIDTH);
        yIn  = y10 < 10'(SCREEN_HEIGHT);
        effW = 10'd1;
        effH = 10'd1;
        if (op == OP_FILL_RECT) begin
            effW = min10({1'b0, cmdWidth}, 10'(SCREEN_WIDTH) - x10);
            effH = min10({2'b00, cmdHeight}, 10'(SCREEN_HEIGHT) - y10);
        end
        issue = xIn && yIn && (effW != 10'd0) && (effH != 10'd0) && (op != OP_RESERVED);
    end

    rect_scanner scanner (
        .clock   (clock),
        .reset   (reset),
        .load    (startCmd),
        .advance (advance),
        .startX  (cmdX),
        .startY  (cmdY),
        .width   (effW),
        .height  (effH),
        .x       (memoryXCoord),
        .y       (memoryYCoord),
        .last    (last)
    );

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= S_IDLE;
            cmdReady           <= 1'b1;
            busy               <= 1'b0;
            readValid          <= 1'b0;
            readData           <= '0;
            memoryWriteRequest <= 1'b0;
            memoryReadRequest  <= 1'b0;
            memoryWriteData    <= '0;
        end else begin
            state              <= nextState;
            cmdReady           <= readyNext;
            busy               <= !readyNext;
            readValid          <= readValidNext;
            readData           <= readDataNext;
            memoryWriteRequest <= writeReqNext;
            memoryReadRequest  <= readReqNext;
            memoryWriteData    <= writeDataNext;
        end
    end

    // Next-state logic; completions only count in their matching state.
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:  if (startCmd) nextState = (op == OP_READ_PIXEL) ? S_READ : S_WRITE;
            S_WRITE: if (memoryWriteComplete) nextState = S_GAP;
            S_READ:  if (memoryReadComplete) nextState = S_GAP;
            S_GAP:   nextState = last ? S_IDLE : S_WRITE;
            default: nextState = S_IDLE;
        endcase
    end

    // Output next-values. Requests follow the state they lead into, so the
    // S_GAP cycle guarantees a low cycle between any two requests.
    always_comb begin
        readyNext     = (nextState == S_IDLE);
        writeReqNext  = (nextState == S_WRITE);
        readReqNext   = (nextState == S_READ);
        readValidNext = readDone || readMiss;
        readDataNext  = readData;
        if (readDone)
            readDataNext = memoryReadData;
        else if (readMiss)
            readDataNext = '0;
        writeDataNext = memoryWriteData;
        if (startCmd && (op != OP_READ_PIXEL))
            writeDataNext = cmdColor;
    end

endmodule

// File: doc/pixel_command_engine.md
Name: pixel_command_engine

Overview:
- Initiator on the client side of the frame-buffer memory manager's request port.
- Accepts host drawing commands (single-pixel write, single-pixel read, rectangle fill) and turns each into a sequence of memoryWriteRequest/memoryReadRequest transactions.
- Every transaction is held until the manager's completion pulse arrives.
- Sits between the host/CPU command decoder and the memory manager.

Parameters:
- SCREEN_WIDTH, 320, visible pixels per line; x coordinates at or above this value are clipped.
- SCREEN_HEIGHT, 240, visible lines; y coordinates at or above this value are clipped.

Ports:
- clock  in  1  system clock, same clock as the memory manager
- reset  in  1  synchronous, active-high
- cmdValid  in  1  command present
- cmdReady  out  1  engine can accept a command
- cmdOp  in  2  0=WRITE_PIXEL, 1=READ_PIXEL, 2=FILL_RECT, 3=reserved (treated as no-op)
- cmdX  in  9  start x
- cmdY  in  8  start y
- cmdWidth  in  9  rectangle width in pixels (FILL_RECT only)
- cmdHeight  in  8  rectangle height in lines (FILL_RECT only)
- cmdColor  in  8  pixel value to write
- readData  out  8  result of READ_PIXEL
- readValid  out  1  one-cycle pulse; readData is valid in that cycle
- busy  out  1  a command is in progress
- memoryXCoord  out  9  transaction x
- memoryYCoord  out  8  transaction y
- memoryWriteRequest  out  1  write request level
- memoryReadRequest  out  1  read request level
- memoryWriteData  out  8  write value
- memoryReadData  in  8  read value from the manager
- memoryWriteComplete  in  1  one-cycle completion pulse for a write
- memoryReadComplete  in  1  one-cycle completion pulse for a read

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - cmdReady=1, busy=0, readValid=0, readData=0.
  - Both request outputs 0.
  - memoryXCoord=0, memoryYCoord=0, memoryWriteData=0.
  - State is S_IDLE.
- Reset mid-transaction: the request drops at the reset edge and the in-flight command is abandoned. Any completion pulse that arrives later is ignored.
- Command accept:
  - A command is accepted on a clock edge where cmdValid && cmdReady.
  - cmdReady=1 only in S_IDLE. It falls on the edge that accepts the command.
  - busy = !cmdReady.
- States:
  - S_IDLE:
    - WRITE_PIXEL in range -> S_WRITE.
    - READ_PIXEL in range -> S_READ.
    - FILL_RECT with a non-empty clipped area -> S_WRITE at (cmdX, cmdY).
    - Anything else stays in S_IDLE.
  - S_WRITE: memoryWriteRequest=1 with coordinates and data stable. On memoryWriteComplete -> S_GAP.
  - S_READ: memoryReadRequest=1 with coordinates stable. On memoryReadComplete:
    - readData <= memoryReadData.
    - readValid pulses on the next cycle.
    - Next state is S_GAP.
  - S_GAP: both requests low for exactly one cycle.
    - If the current command has more pixels, advance to the next pixel -> S_WRITE.
    - Otherwise -> S_IDLE with cmdReady=1.
- Request rules:
  - The request is asserted on the edge that enters S_WRITE/S_READ.
  - The request drops on the edge after the completion pulse is sampled.
  - There are never two back-to-back request cycles without a low cycle between them, so the manager cannot double-issue.
  - Coordinates and data change only while the request is low.
  - Read and write requests are never high together.
- Completion pulses:
  - A pulse in a non-matching state (e.g. memoryReadComplete during S_WRITE) is ignored.
  - A pulse in S_IDLE or S_GAP is ignored.
- Clipping (computed at accept):
  - Effective width = min(cmdWidth, SCREEN_WIDTH - cmdX).
  - Effective height = min(cmdHeight, SCREEN_HEIGHT - cmdY).
  - If cmdX >= SCREEN_WIDTH or cmdY >= SCREEN_HEIGHT, or either effective dimension is 0, the command issues no requests. cmdReady stays 1 and the command is consumed.
  - Out-of-range WRITE_PIXEL is consumed with no request.
  - Out-of-range READ_PIXEL is consumed with no request; readValid pulses on the next cycle with readData=0.
- Rectangle scan order:
  - Row-major: x increments from cmdX to cmdX+effW-1, then x returns to cmdX and y increments.
  - The command ends after pixel (cmdX+effW-1, cmdY+effH-1).
  - Internal arithmetic is 10 bits wide so that x+width cannot wrap.

Decomposition:
- Package pixel_cmd_pkg:
  - op enum (OP_WRITE_PIXEL, OP_READ_PIXEL, OP_FILL_RECT).
  - Engine state enum (S_IDLE, S_WRITE, S_READ, S_GAP).
  - SCREEN_WIDTH/SCREEN_HEIGHT defaults.
- Sub-module rect_scanner:
  - Holds the x/y counters, clipped bounds and last-pixel flag.
  - Inputs: load and advance strobes. Outputs: current x/y and last.

Test Plan:
- Bench environment: each scenario runs against the memory manager plus an SRAM model.
- WRITE_PIXEL x=5,y=7,color=0xA5:
  - Exactly one write request; SRAM[{7,5}]=0xA5.
  - cmdReady returns 1 one cycle after the S_GAP cycle.
- READ_PIXEL x=5,y=7 after the write above: exactly one read request; readValid pulses once with readData=0xA5.
- FILL_RECT x=318,y=238,w=4,h=4,color=0x3C:
  - Exactly 4 writes, in order (318,238),(319,238),(318,239),(319,239).
  - No write is issued at x>=320 or y>=240.
- FILL_RECT w=0 or x=320:
  - Zero requests; cmdReady high on the cycle after accept.
  - READ_PIXEL y=240 -> readValid with readData=0.
- Reset asserted for one cycle while S_WRITE is waiting for completion:
  - memoryWriteRequest=0 on the next edge.
  - The late completion pulse is ignored.
  - The next WRITE_PIXEL command runs normally.
- Throughout every scenario, checker asserts:
  - A request is never high in the cycle immediately following its completion pulse.
  - Read and write requests are never high together.
